// File: rtl/etapa_busqueda.sv
// Instruction fetch stage: program counter plus the IF/ID pipeline register.
// A small FSM tracks start-up, normal flow, hazard stalls and branch flushes,
// and counts the bubbles injected into the decode stage.
module etapa_busqueda #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        reloj,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_out,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [1:0]  estado,
    output logic [15:0] burbujas
);

    typedef enum logic [1:0] {
        INICIO   = 2'b00,
        CORRE    = 2'b01,
        DETENIDO = 2'b10,
        VACIADO  = 2'b11
    } state_t;

    state_t state;

    // Address of the next sequential instruction; wraps modulo 2^32.
    logic [31:0] pc_next;
    assign pc_next = pc_out + PC_STEP;

    assign estado = state;

    // Fetch FSM: every output is a register updated here.
    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values, exactly like the flops they describe.
    always_ff @(posedge reloj or posedge rst) begin
        if (rst) begin
            // NOTE: reset is asynchronous, so the outputs go to their idle
            // values immediately, without waiting for a clock edge.
            state       <= INICIO;
            pc_out      <= RESET_PC;
            if_id_instr <= 32'h0;
            if_id_pc4   <= 32'h0;
            if_id_valid <= 1'b0;
            burbujas    <= 16'h0;
        end else begin
            case (state)
                INICIO: begin
                    // First edge after reset: no fetch yet, the empty slot
                    // counts as a bubble; redirects are ignored here.
                    state <= CORRE;
                    if (burbujas != 16'hFFFF) begin
                        burbujas <= burbujas + 16'd1;
                    end
                end

                default: begin
                    if (branch_taken) begin
                        // Redirect wins over stall: flush the wrong-path
                        // instruction and restart at the word-aligned target.
                        state       <= VACIADO;
                        pc_out      <= {branch_target[31:2], 2'b00};
                        if_id_instr <= 32'h0;
                        if_id_pc4   <= 32'h0;
                        if_id_valid <= 1'b0;
                        if (burbujas != 16'hFFFF) begin
                            burbujas <= burbujas + 16'd1;
                        end
                    end else if (stall) begin
                        // Freeze the PC and the IF/ID register.
                        state <= DETENIDO;
                    end else begin
                        // Capture the current word and advance.
                        state       <= CORRE;
                        if_id_instr <= instr_in;
                        if_id_pc4   <= pc_next;
                        if_id_valid <= 1'b1;
                        pc_out      <= pc_next;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/etapa_busqueda.md
ETAPA_BUSQUEDA -- requirements
Module: etapa_busqueda

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; clock port reloj (rising edge), reset port rst.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-003 Parameter PC_STEP, default 4: sequential PC increment.
REQ-004 reloj  input  1  system clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 stall  input  1  hazard request; freeze PC and IF/ID register.
REQ-007 branch_taken  input  1  redirect request from the downstream datapath (Branch & Zero).
REQ-008 branch_target  input  32  redirect address.
REQ-009 instr_in  input  32  word from the combinational instruction memory at address pc_out.
REQ-010 pc_out  output  32  current fetch address, registered.
REQ-011 if_id_instr  output  32  captured instruction for the decode stage.
REQ-012 if_id_pc4  output  32  captured fetch address plus PC_STEP.
REQ-013 if_id_valid  output  1  if_id_instr holds a real instruction.
REQ-014 estado  output  2  FSM state: 00 INICIO, 01 CORRE, 10 DETENIDO, 11 VACIADO.
REQ-015 burbujas  output  16  count of inserted bubbles, saturating.

Function
REQ-016 All state SHALL update only on the rising edge of reloj, except for reset.
REQ-017 In INICIO, the next edge SHALL go to CORRE without advancing the PC or capturing; if_id_valid stays 0 and burbujas increments.
REQ-018 Capture edge (state CORRE or VACIADO, stall=0, branch_taken=0) SHALL perform: if_id_instr<=instr_in; if_id_pc4<=pc_out+PC_STEP; if_id_valid<=1; pc_out<=pc_out+PC_STEP; next state CORRE.
REQ-019 Stall edge (state CORRE/VACIADO/DETENIDO, stall=1, branch_taken=0) SHALL hold pc_out and all if_id_* outputs; next state DETENIDO.
REQ-020 In DETENIDO with stall=0 and branch_taken=0, the edge SHALL perform a capture per REQ-018; next state CORRE.
REQ-021 Redirect edge (branch_taken=1 in CORRE/DETENIDO/VACIADO) SHALL perform: pc_out<={branch_target[31:2],2'b00}; if_id_instr<=32'h0 (NOP); if_id_pc4<=0; if_id_valid<=0; next state VACIADO; burbujas increments.
REQ-022 branch_taken SHALL take priority over stall when both are asserted on the same edge.
REQ-023 branch_taken SHALL be ignored in INICIO.
REQ-024 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
REQ-025 burbujas SHALL saturate at 16'hFFFF and never wrap.
REQ-026 Outputs SHALL NOT depend combinationally on any input; all are registered.
REQ-027 Exactly one instruction per capture edge; none duplicated or dropped across any stall length.

Reset
REQ-028 While rst=1: pc_out=RESET_PC; if_id_instr=0; if_id_pc4=0; if_id_valid=0; estado=INICIO; burbujas=0; this takes effect immediately, independent of reloj.
REQ-029 Reset asserted mid-stall or mid-redirect SHALL abandon that operation; the first edge after deassertion follows REQ-017.

Verification
REQ-030 Reset then 4 edges, stall=0, memory word = address -> estado 00,01,01,01; pc_out 0,0,4,8,C; if_id_instr 0,0,0,4,8 with valid rising after edge 2; burbujas=1.
REQ-031 From CORRE at pc_out=8, stall=1 for 3 edges -> pc_out stays 8, if_id unchanged, estado=10; stall low one edge -> if_id_instr=mem[8], pc_out=C, estado=01.
REQ-032 At pc_out=10, branch_taken=1, branch_target=32'h0000_0043 -> pc_out=0x40, if_id_valid=0, if_id_instr=0, estado=11, burbujas +1; next edge captures mem[0x40], if_id_pc4=0x44.
REQ-033 branch_taken=1 and stall=1 on the same edge -> redirect behaviour of REQ-032, estado=11.
REQ-034 RESET_PC=32'hFFFF_FFF8, run 3 edges -> pc_out FFFF_FFF8, FFFF_FFF8, FFFF_FFFC, 0000_0000; if_id_pc4 on the final capture = 0.
REQ-035 Assert rst asynchronously between edges while in DETENIDO -> outputs match REQ-028 before the next edge.
